// File: rtl/tokenizer_pkg.sv
// Shared vocabulary definitions for the token encoder/decoder pair.
package tokenizer_pkg;

  localparam logic [7:0] TERM_BYTE_DEF = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEEK_REQ  = 3'd1,
    S_SEEK_CHK  = 3'd2,
    S_EMIT_REQ  = 3'd3,
    S_EMIT_CHK  = 3'd4,
    S_EMIT_HOLD = 3'd5,
    S_FINISH    = 3'd6
  } dec_state_t;

  // Last byte address of a 2**aw byte vocabulary image.
  function automatic int unsigned mem_end_addr(input int unsigned aw);
    return (32'd1 << aw) - 32'd1;
  endfunction

endpackage

// File: rtl/token_decoder.sv
// Walks the vocab SRAM to the entry for a token index and streams that
// entry's bytes out on a valid/ready interface with a last-byte flag.
module token_decoder
  import tokenizer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] TERM_BYTE = DATA_WIDTH'(TERM_BYTE_DEF)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  tok_valid,
  output logic                  tok_ready,
  input  logic [ADDR_WIDTH-1:0] tok_id,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   len,
  output logic                  err_not_found
);

  localparam int unsigned LEN_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] END_ADDR = ADDR_WIDTH'(mem_end_addr(ADDR_WIDTH));

  dec_state_t            r_state,    w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt,      w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_addr,     w_addr_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic                  r_out_valid, w_out_valid_nxt;
  logic [DATA_WIDTH-1:0] r_out_data, w_out_data_nxt;
  logic                  r_out_last, w_out_last_nxt;
  logic                  r_pf_done,  w_pf_done_nxt;
  logic                  r_err,      w_err_nxt;
  logic                  r_done,     w_done_nxt;
  logic                  r_err_nf,   w_err_nf_nxt;
  logic [LEN_W-1:0]      r_len,      w_len_nxt;
  logic                  r_tok_ready, w_tok_ready_nxt;
  logic                  w_tok_acc;
  logic                  w_is_term;

  assign w_tok_acc = tok_valid & r_tok_ready;
  assign w_is_term = (mem_dout == TERM_BYTE);

  // Next-state and datapath updates; mem_addr runs one address ahead while emitting.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_addr_nxt      = r_addr;
    w_mem_addr_nxt  = r_mem_addr;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_last_nxt  = r_out_last;
    w_pf_done_nxt   = r_pf_done;
    w_err_nxt       = r_err;
    w_len_nxt       = r_len;
    case (r_state)
      S_IDLE: begin
        if (w_tok_acc) begin
          w_cnt_nxt      = tok_id;
          w_addr_nxt     = '0;
          w_mem_addr_nxt = '0;
          w_len_nxt      = '0;
          w_err_nxt      = 1'b0;
          w_state_nxt    = (tok_id == '0) ? S_EMIT_REQ : S_SEEK_REQ;
        end
      end
      S_SEEK_REQ: w_state_nxt = S_SEEK_CHK;
      S_SEEK_CHK: begin
        if (w_is_term) w_cnt_nxt = r_cnt - ADDR_WIDTH'(1);
        if (w_is_term && (r_cnt == ADDR_WIDTH'(1))) begin
          // An entry starting past the memory end is empty, never a wrap to 0.
          if (r_addr == END_ADDR) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_addr_nxt     = r_addr + ADDR_WIDTH'(1);
            w_mem_addr_nxt = r_addr + ADDR_WIDTH'(1);
            w_state_nxt    = S_EMIT_REQ;
          end
        end else if (r_addr == END_ADDR) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_FINISH;
        end else begin
          w_addr_nxt     = r_addr + ADDR_WIDTH'(1);
          w_mem_addr_nxt = r_addr + ADDR_WIDTH'(1);
          w_state_nxt    = S_SEEK_REQ;
        end
      end
      S_EMIT_REQ: begin
        w_mem_addr_nxt = r_addr + ADDR_WIDTH'(1);
        w_state_nxt    = S_EMIT_CHK;
      end
      S_EMIT_CHK: begin
        if (w_is_term) begin
          w_state_nxt = S_FINISH;
        end else begin
          w_out_data_nxt = mem_dout;
          w_state_nxt    = S_EMIT_HOLD;
          if (r_addr == END_ADDR) begin
            w_out_valid_nxt = 1'b1;
            w_out_last_nxt  = 1'b1;
            w_pf_done_nxt   = 1'b1;
          end else begin
            w_pf_done_nxt   = 1'b0;
          end
        end
      end
      S_EMIT_HOLD: begin
        // out_valid waits one cycle for the look-ahead byte so out_last is never late.
        if (!r_pf_done) begin
          w_pf_done_nxt   = 1'b1;
          w_out_valid_nxt = 1'b1;
          w_out_last_nxt  = w_is_term;
        end else if (out_ready) begin
          w_len_nxt       = r_len + LEN_W'(1);
          w_out_valid_nxt = 1'b0;
          w_out_last_nxt  = 1'b0;
          if (r_out_last) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_addr_nxt     = r_addr + ADDR_WIDTH'(1);
            w_mem_addr_nxt = r_addr + ADDR_WIDTH'(2);
            w_state_nxt    = S_EMIT_CHK;
          end
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    w_done_nxt      = (w_state_nxt == S_FINISH);
    w_err_nf_nxt    = (w_state_nxt == S_FINISH) & w_err_nxt;
    w_tok_ready_nxt = (w_state_nxt == S_IDLE);
  end

  // State register; cs low freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_mem_addr  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_pf_done   <= 1'b0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_err_nf    <= 1'b0;
      r_len       <= '0;
      r_tok_ready <= 1'b0;
    end else if (cs) begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_addr      <= w_addr_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_last  <= w_out_last_nxt;
      r_pf_done   <= w_pf_done_nxt;
      r_err       <= w_err_nxt;
      r_done      <= w_done_nxt;
      r_err_nf    <= w_err_nf_nxt;
      r_len       <= w_len_nxt;
      r_tok_ready <= w_tok_ready_nxt;
    end
  end

  assign tok_ready     = r_tok_ready & cs;
  assign mem_addr      = r_mem_addr;
  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign out_last      = r_out_last;
  assign done          = r_done;
  assign len           = r_len;
  assign err_not_found = r_err_nf;

endmodule

// File: tb/tb_token_decoder.sv
// Self-checking bench for token_decoder against a terminator-walking reference model.
module tb_token_decoder;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n, cs, tok_valid, tok_ready, out_valid, out_ready, out_last;
  logic          done, err_not_found;
  logic [AW-1:0] tok_id, mem_addr;
  logic [DW-1:0] mem_dout, out_data;
  logic [AW:0]   len;
  logic [DW-1:0] mem [DEPTH];

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] exp_q[$];
  bit            exp_err;

  always #5 clk = ~clk;

  always @(posedge clk) mem_dout <= mem[mem_addr];

  token_decoder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TERM_BYTE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_id(tok_id),
    .mem_addr(mem_addr), .mem_dout(mem_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done), .len(len), .err_not_found(err_not_found)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entry k starts right after the k-th terminator; the memory end closes any entry.
  task automatic model(input int tid);
    int pos;
    int found;
    pos = 0;
    exp_q.delete();
    exp_err = 1'b0;
    for (int k = 0; k < tid; k++) begin
      found = -1;
      for (int a = pos; a < DEPTH; a++) begin
        if (mem[a] == 8'h00) begin
          found = a;
          break;
        end
      end
      if (found < 0) begin
        exp_err = 1'b1;
        return;
      end
      pos = found + 1;
    end
    while (pos < DEPTH && mem[pos] != 8'h00) begin
      exp_q.push_back(mem[pos]);
      pos++;
    end
  endtask

  task automatic load_cat();
    logic [DW-1:0] img [12];
    img = '{8'h63, 8'h61, 8'h74, 8'h00, 8'h64, 8'h6f, 8'h67, 8'h00, 8'h00, 8'h6f, 8'h78, 8'h00};
    for (int a = 0; a < DEPTH; a++) mem[a] = (a < 12) ? img[a] : 8'h00;
  endtask

  task automatic run_tok(input int tid, input int ready_pct, input int stall_idx, input int stall_n,
                         input int cs_at, input int cs_n, output int lat);
    int          nget;
    int          wait_n;
    int          stall_left;
    bit          seen_done;
    bit          holding;
    bit          stable_bad;
    bit          busy_ready;
    logic [DW-1:0] held;
    nget = 0; seen_done = 0; holding = 0; stable_bad = 0; busy_ready = 0;
    stall_left = stall_n;
    model(tid);
    wait_n = 0;
    while (!tok_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    check("tok_ready_idle", tok_ready, 1);
    tok_valid = 1'b1;
    tok_id    = AW'(tid);
    @(negedge clk);
    tok_valid = 1'b0;
    lat = 0;
    while (!seen_done && lat < 400) begin
      if (done) begin
        seen_done = 1;
        check("len", len, exp_q.size());
        check("err_not_found", err_not_found, exp_err);
      end else begin
        if (tok_ready) busy_ready = 1;
        cs = !(cs_at >= 0 && lat >= cs_at && lat < cs_at + cs_n);
        if (out_valid && nget == stall_idx && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = ($urandom_range(99) < ready_pct);
        end
        if (holding && (!out_valid || out_data !== held)) stable_bad = 1;
        if (out_valid && out_ready && cs) begin
          check("byte", out_data, (nget < exp_q.size()) ? exp_q[nget] : 32'hdead);
          check("out_last", out_last, (nget == exp_q.size() - 1));
          nget++;
          holding = 0;
        end else if (out_valid) begin
          holding = 1;
          held    = out_data;
        end
        @(negedge clk);
        lat++;
      end
    end
    cs = 1'b1;
    out_ready = 1'b1;
    check("done_seen", seen_done, 1);
    check("byte_count", nget, exp_q.size());
    check("hold_stable", stable_bad, 0);
    check("tok_ready_busy", busy_ready, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  task automatic check_reset_vals();
    check("rst_tok_ready", tok_ready, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_len", len, 0);
    check("rst_err", err_not_found, 0);
  endtask

  initial begin
    int lat_ref;
    int lat_cs;
    int lat;
    int n;
    bit done_seen;
    rst_n = 1'b0; cs = 1'b1; tok_valid = 1'b0; tok_id = '0; out_ready = 1'b1;
    load_cat();
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);
    check("tok_ready_after_rst", tok_ready, 1);

    run_tok(0, 100, -1, 0, -1, 0, lat);
    run_tok(1, 100, -1, 0, -1, 0, lat);
    run_tok(3, 100, -1, 0, -1, 0, lat);
    run_tok(2, 100, -1, 0, -1, 0, lat);
    run_tok(15, 100, -1, 0, -1, 0, lat);
    run_tok(8, 100, -1, 0, -1, 0, lat);
    run_tok(1, 100, 1, 5, -1, 0, lat);

    // Reset in the middle of emitting token 0, right after 'c' is taken.
    tok_valid = 1'b1; tok_id = '0; out_ready = 1'b1;
    @(negedge clk);
    tok_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_first_byte", out_data, 8'h63);
    @(negedge clk);
    rst_n = 1'b0;
    done_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) done_seen = 1;
    end
    check("rst_no_done", done_seen, 0);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);
    check("tok_ready_after_rst2", tok_ready, 1);
    run_tok(3, 100, -1, 0, -1, 0, lat);

    run_tok(3, 100, -1, 0, -1, 0, lat_ref);
    run_tok(3, 100, -1, 0, 4, 3, lat_cs);
    check("cs_delay", lat_cs - lat_ref, 3);

    for (int it = 0; it < 30; it++) begin
      for (int a = 0; a < DEPTH; a++)
        mem[a] = ($urandom_range(3) == 0) ? 8'h00 : DW'($urandom_range(255, 1));
      run_tok($urandom_range(15), $urandom_range(100, 30), -1, 0, -1, 0, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
